// File: rtl/acc_core_mc_if.sv
// Memory bus between acc_core_mc and its external single-port memory.
// The core drives req/we/addr/wdata; the memory answers with ack/rdata.
interface acc_core_mc_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/acc_core_mc.sv
// acc_core_mc: parametrised multi-cycle accumulator core.
// Instruction word = {opcode[2:0], ..., oper[ADDR_W-1:0]}.
// Every memory state spends one cycle raising the request and then waits
// for ack, so a zero-wait access costs two cycles.
// Optional macro ACC_CORE_RETIRE_CNT_EN enables the 32-bit retired counter;
// without it, retired is tied to zero.
module acc_core_mc #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 5,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic                clk,
   input  logic                rst,
   acc_core_mc_if.master       mem,
   input  logic                resume,
   output logic [ADDR_W-1:0]   pc,
   output logic [DATA_W-1:0]   acc,
   output logic                zero,
   output logic                halted,
   output logic [31:0]         retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_READ   = 3'd2,
      S_WRITE  = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] pc_r, pc_s;
   logic [DATA_W-1:0] acc_r, acc_s;
   logic [2:0]        op_r, op_s;
   logic [ADDR_W-1:0] oper_r, oper_s;
   logic              req_r, req_s;
   logic              we_r, we_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] wdata_r, wdata_s;
   logic              halted_r;

   // Controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, datapath and bus request decisions
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      acc_s   = acc_r;
      op_s    = op_r;
      oper_s  = oper_r;
      req_s   = req_r;
      we_s    = we_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      case (state_r)
         S_FETCH: begin
            if (!req_r) begin
               req_s  = 1'b1;
               we_s   = 1'b0;
               addr_s = pc_r;
            end else if (mem.mem_ack) begin
               op_s    = mem.mem_rdata[DATA_W-1 -: 3];
               oper_s  = mem.mem_rdata[ADDR_W-1:0];
               pc_s    = pc_r + PC_ONE;
               req_s   = 1'b0;
               state_s = S_DECODE;
            end else begin
               state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            case (op_r)
               OP_HLT: state_s = S_HALT;
               OP_SKZ: begin
                  if (acc_r == {DATA_W{1'b0}}) begin
                     pc_s = pc_r + PC_ONE;
                  end else begin
                     pc_s = pc_r;
                  end
                  state_s = S_FETCH;
               end
               OP_JMP: begin
                  pc_s    = oper_r;
                  state_s = S_FETCH;
               end
               OP_STO:  state_s = S_WRITE;
               default: state_s = S_READ;
            endcase
         end
         S_READ: begin
            if (!req_r) begin
               req_s  = 1'b1;
               we_s   = 1'b0;
               addr_s = oper_r;
            end else if (mem.mem_ack) begin
               case (op_r)
                  OP_ADD:  acc_s = acc_r + mem.mem_rdata;
                  OP_AND:  acc_s = acc_r & mem.mem_rdata;
                  OP_XOR:  acc_s = acc_r ^ mem.mem_rdata;
                  OP_LDA:  acc_s = mem.mem_rdata;
                  default: acc_s = acc_r;
               endcase
               req_s   = 1'b0;
               state_s = S_FETCH;
            end else begin
               state_s = S_READ;
            end
         end
         S_WRITE: begin
            if (!req_r) begin
               req_s   = 1'b1;
               we_s    = 1'b1;
               addr_s  = oper_r;
               wdata_s = acc_r;
            end else if (mem.mem_ack) begin
               req_s   = 1'b0;
               state_s = S_FETCH;
            end else begin
               state_s = S_WRITE;
            end
         end
         S_HALT: begin
            if (resume) begin
               state_s = S_FETCH;
            end else begin
               state_s = S_HALT;
            end
         end
         default: state_s = S_FETCH;
      endcase
   end

   // Datapath and registered bus outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r     <= RESET_PC;
         acc_r    <= {DATA_W{1'b0}};
         op_r     <= 3'd0;
         oper_r   <= {ADDR_W{1'b0}};
         req_r    <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= {ADDR_W{1'b0}};
         wdata_r  <= {DATA_W{1'b0}};
         halted_r <= 1'b0;
      end else begin
         pc_r     <= pc_s;
         acc_r    <= acc_s;
         op_r     <= op_s;
         oper_r   <= oper_s;
         req_r    <= req_s;
         we_r     <= we_s;
         addr_r   <= addr_s;
         wdata_r  <= wdata_s;
         halted_r <= (state_s == S_HALT);
      end
   end

`ifdef ACC_CORE_RETIRE_CNT_EN
   logic        retire_s;
   logic [31:0] retired_r;

   // An instruction retires when it hands control back to FETCH or enters HALT
   assign retire_s = ((state_r == S_DECODE) && ((state_s == S_FETCH) || (state_s == S_HALT))) ||
                     (((state_r == S_READ) || (state_r == S_WRITE)) && (state_s == S_FETCH));

   // Retired-instruction counter, wraps at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_r <= 32'd0;
      end else if (retire_s) begin
         retired_r <= retired_r + 32'd1;
      end else begin
         retired_r <= retired_r;
      end
   end

   assign retired = retired_r;
`else
   assign retired = 32'd0;
`endif

   assign mem.mem_req   = req_r;
   assign mem.mem_we    = we_r;
   assign mem.mem_addr  = addr_r;
   assign mem.mem_wdata = wdata_r;
   assign pc            = pc_r;
   assign acc           = acc_r;
   assign zero          = (acc_r == {DATA_W{1'b0}});
   assign halted        = halted_r;

endmodule

// File: tb/tb_acc_core_mc.sv
// Self-checking bench for acc_core_mc: an 8/5 instance against a
// wait-state-capable memory model and a 16/8 instance for wide arithmetic.
module tb_acc_core_mc;

`ifdef ACC_CORE_RETIRE_CNT_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef logic [16:0] acc_t;   // {we, 3'b0, addr[4:0], data[7:0]}

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_w = 1'b1;
   logic resume = 1'b0;
   logic resume_w = 1'b0;
   always #5 clk = ~clk;

   acc_core_mc_if #(.DATA_W(8), .ADDR_W(5)) mif ();
   logic [4:0]  pc;
   logic [7:0]  acc;
   logic        zero, halted;
   logic [31:0] retired;

   acc_core_mc #(.DATA_W(8), .ADDR_W(5), .RESET_PC(5'd0)) dut (
      .clk(clk), .rst(rst), .mem(mif.master), .resume(resume),
      .pc(pc), .acc(acc), .zero(zero), .halted(halted), .retired(retired)
   );

   acc_core_mc_if #(.DATA_W(16), .ADDR_W(8)) wif ();
   logic [7:0]  pc_w;
   logic [15:0] acc_w;
   logic        zero_w, halted_w;
   logic [31:0] retired_w;

   acc_core_mc #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'd0)) dut_w (
      .clk(clk), .rst(rst_w), .mem(wif.master), .resume(resume_w),
      .pc(pc_w), .acc(acc_w), .zero(zero_w), .halted(halted_w), .retired(retired_w)
   );

   int passed = 0;
   int total  = 0;

   // memory model state for the 8-bit instance
   logic [7:0]  mem [32];
   int          wait_n = 0;
   bit          hold_we = 1'b0;
   int          cnt = 0;
   int          stab_err = 0;
   int          nwrites = 0;
   logic        l_we;
   logic [4:0]  l_addr;
   logic [7:0]  l_wdata;
   acc_t        act_q [$];
   acc_t        exp_q [$];
   logic [15:0] memw [256];

   // 8-bit memory: answers after wait_n wait cycles, logs every completed access
   always @(negedge clk) begin
      mif.mem_ack = 1'b0;
      if (mif.mem_req === 1'b1) begin
         if (cnt == 0) begin
            l_we = mif.mem_we; l_addr = mif.mem_addr; l_wdata = mif.mem_wdata;
         end else if ({mif.mem_we, mif.mem_addr, mif.mem_wdata} !== {l_we, l_addr, l_wdata}) begin
            stab_err++;
         end
         if (cnt >= wait_n && !(hold_we && mif.mem_we)) begin
            mif.mem_ack = 1'b1;
            if (mif.mem_we) begin
               mem[mif.mem_addr] = mif.mem_wdata;
               nwrites++;
               act_q.push_back({1'b1, 3'b000, mif.mem_addr, mif.mem_wdata});
            end else begin
               mif.mem_rdata = mem[mif.mem_addr];
               act_q.push_back({1'b0, 3'b000, mif.mem_addr, mem[mif.mem_addr]});
            end
            cnt = 0;
         end else begin
            cnt++;
         end
      end else begin
         cnt = 0;
      end
   end

   // 16-bit memory: zero-wait
   always @(negedge clk) begin
      wif.mem_ack = 1'b0;
      if (wif.mem_req === 1'b1) begin
         wif.mem_ack = 1'b1;
         if (wif.mem_we) memw[wif.mem_addr] = wif.mem_wdata;
         else wif.mem_rdata = memw[wif.mem_addr];
      end
   end

   task automatic exp_acc(input logic we, input logic [4:0] a, input logic [7:0] d);
      exp_q.push_back({we, 3'b000, a, d});
   endtask

   task automatic begin_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      wait_n = 0; hold_we = 1'b0; nwrites = 0; stab_err = 0;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      act_q.delete(); exp_q.delete();
   endtask

   task automatic end_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_to_halt(input int budget, output int cyc, output bit ok);
      cyc = 0;
      while (halted !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      ok = (halted === 1'b1);
   endtask

   task automatic pulse_resume();
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
   endtask

   task automatic test_reset();
      int cyc; bit ok; acc_t e, a;
      begin_reset();
      #1;
      total++; if (mif.mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mif.mem_req); else passed++;
      total++; if (mif.mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mif.mem_we); else passed++;
      total++; if (mif.mem_addr !== 5'd0) $display("FAIL rst_addr: got %h want 0", mif.mem_addr); else passed++;
      total++; if (mif.mem_wdata !== 8'd0) $display("FAIL rst_wdata: got %h want 0", mif.mem_wdata); else passed++;
      total++; if (pc !== 5'd0) $display("FAIL rst_pc: got %h want 0", pc); else passed++;
      total++; if (acc !== 8'd0) $display("FAIL rst_acc: got %h want 0", acc); else passed++;
      total++; if (zero !== 1'b1) $display("FAIL rst_zero: got %b want 1", zero); else passed++;
      total++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else passed++;
      total++; if (retired !== 32'd0) $display("FAIL rst_retired: got %0d want 0", retired); else passed++;
      mem[0] = 8'hA5; mem[5] = 8'h3C; mem[1] = 8'h00;
      exp_acc(1'b0, 5'd0, 8'hA5); exp_acc(1'b0, 5'd5, 8'h3C); exp_acc(1'b0, 5'd1, 8'h00);
      end_reset();
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (mif.mem_req !== 1'b1 && cyc < 10);
      total++; if (cyc !== 1) $display("FAIL first_req_delay: got %0d want 1", cyc); else passed++;
      total++; if (mif.mem_addr !== 5'd0) $display("FAIL first_req_addr: got %h want 0", mif.mem_addr); else passed++;
      repeat (5) @(negedge clk);
      total++; if (acc !== 8'h3C) $display("FAIL lda_acc: got %h want 3c", acc); else passed++;
      total++; if (pc !== 5'd1) $display("FAIL lda_pc: got %h want 1", pc); else passed++;
      total++; if ({mif.mem_req, mif.mem_addr} !== {1'b1, 5'd1}) $display("FAIL lda_latency: got req %b addr %h want 1/01", mif.mem_req, mif.mem_addr); else passed++;
      run_to_halt(50, cyc, ok);
      total++; if (!ok) $display("FAIL reset_halt_timeout: got running want halted"); else passed++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (act_q.size() == 0) $display("FAIL reset_seq: got none want %h", e);
         else begin a = act_q.pop_front(); if (a !== e) $display("FAIL reset_seq: got %h want %h", a, e); else passed++; end
      end
      total++; if (retired !== (RC ? 32'd2 : 32'd0)) $display("FAIL reset_retired: got %0d want %0d", retired, RC ? 2 : 0); else passed++;
   endtask

   task automatic test_alu();
      int cyc; bit ok;
      begin_reset();
      mem[0] = 8'hB0; mem[1] = 8'h51; mem[2] = 8'h00; mem[3] = 8'h92; mem[4] = 8'h00;
      mem[16] = 8'hF0; mem[17] = 8'h20; mem[18] = 8'h10;
      end_reset();
      run_to_halt(60, cyc, ok);
      total++; if (!ok) $display("FAIL alu_halt1_timeout: got running want halted"); else passed++;
      total++; if (acc !== 8'h10) $display("FAIL add_wrap_acc: got %h want 10", acc); else passed++;
      total++; if (zero !== 1'b0) $display("FAIL add_wrap_zero: got %b want 0", zero); else passed++;
      pulse_resume();
      run_to_halt(60, cyc, ok);
      total++; if (acc !== 8'h00) $display("FAIL xor_acc: got %h want 00", acc); else passed++;
      total++; if (zero !== 1'b1) $display("FAIL xor_zero: got %b want 1", zero); else passed++;
      total++; if (pc !== 5'd5) $display("FAIL xor_pc: got %h want 5", pc); else passed++;
   endtask

   task automatic test_skz_jmp();
      int cyc; bit ok; acc_t e, a; int bad;
      for (int k = 0; k < 2; k++) begin
         begin_reset();
         mem[0] = 8'hB4; mem[1] = 8'hE3; mem[3] = 8'h20; mem[4] = 8'h00; mem[5] = 8'h00;
         mem[20] = (k == 0) ? 8'h00 : 8'h01;
         exp_acc(1'b0, 5'd0, 8'hB4); exp_acc(1'b0, 5'd20, mem[20]);
         exp_acc(1'b0, 5'd1, 8'hE3); exp_acc(1'b0, 5'd3, 8'h20);
         exp_acc(1'b0, (k == 0) ? 5'd5 : 5'd4, 8'h00);
         end_reset();
         run_to_halt(60, cyc, ok);
         total++; if (pc !== ((k == 0) ? 5'd6 : 5'd5)) $display("FAIL skz_pc_%0d: got %h want %h", k, pc, (k == 0) ? 6 : 5); else passed++;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) $display("FAIL skz_seq_%0d: got none want %h", k, e);
            else begin a = act_q.pop_front(); if (a !== e) $display("FAIL skz_seq_%0d: got %h want %h", k, a, e); else passed++; end
         end
      end
      // JMP 31 at address 31 loops forever
      begin_reset();
      mem[0] = 8'hFF; mem[31] = 8'hFF;
      end_reset();
      repeat (60) @(negedge clk);
      bad = 0;
      for (int i = 1; i < act_q.size(); i++) if (act_q[i] !== {1'b0, 3'b000, 5'd31, 8'hFF}) bad++;
      total++; if (bad !== 0 || act_q.size() < 10) $display("FAIL jmp_loop: got %0d bad of %0d want 0 bad", bad, act_q.size()); else passed++;
      total++; if (nwrites !== 0) $display("FAIL jmp_loop_writes: got %0d want 0", nwrites); else passed++;
      cyc = 0;
      while (mif.mem_req !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
      total++; if (pc !== 5'd31) $display("FAIL jmp_loop_pc: got %h want 1f", pc); else passed++;
      // a non-jump fetched at 31 wraps pc to 0
      begin_reset();
      mem[0] = 8'hFF; mem[31] = 8'h00;
      end_reset();
      run_to_halt(60, cyc, ok);
      total++; if (pc !== 5'd0 || !ok) $display("FAIL pc_wrap: got %h halted %b want 00 halted 1", pc, halted); else passed++;
   endtask

   task automatic test_wait_states();
      int cyc0, cyc3; bit ok; acc_t e, a;
      for (int k = 0; k < 2; k++) begin
         begin_reset();
         wait_n = (k == 0) ? 0 : 3;
         mem[0] = 8'hB4; mem[1] = 8'hC9; mem[2] = 8'h00; mem[20] = 8'h77;
         exp_acc(1'b0, 5'd0, 8'hB4); exp_acc(1'b0, 5'd20, 8'h77); exp_acc(1'b0, 5'd1, 8'hC9);
         exp_acc(1'b1, 5'd9, 8'h77); exp_acc(1'b0, 5'd2, 8'h00);
         end_reset();
         if (k == 0) run_to_halt(100, cyc0, ok); else run_to_halt(100, cyc3, ok);
         total++; if (!ok) $display("FAIL ws_halt_timeout_%0d: got running want halted", k); else passed++;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) $display("FAIL ws_seq_%0d: got none want %h", k, e);
            else begin a = act_q.pop_front(); if (a !== e) $display("FAIL ws_seq_%0d: got %h want %h", k, a, e); else passed++; end
         end
         total++; if (stab_err !== 0) $display("FAIL ws_stable_%0d: got %0d changes want 0", k, stab_err); else passed++;
         total++; if (nwrites !== 1 || mem[9] !== 8'h77) $display("FAIL ws_write_%0d: got %0d writes mem9 %h want 1 77", k, nwrites, mem[9]); else passed++;
         total++; if (acc !== 8'h77 || pc !== 5'd3) $display("FAIL ws_result_%0d: got acc %h pc %h want 77 3", k, acc, pc); else passed++;
      end
      total++; if (cyc3 - cyc0 !== 15) $display("FAIL ws_extra_cycles: got %0d want 15", cyc3 - cyc0); else passed++;
   endtask

   task automatic test_halt_resume();
      int cyc, n; bit ok;
      begin_reset();
      mem[0] = 8'hB4; mem[1] = 8'h54; mem[2] = 8'h00; mem[3] = 8'h00; mem[20] = 8'h05;
      end_reset();
      run_to_halt(60, cyc, ok);
      total++; if (pc !== 5'd3 || acc !== 8'h0A) $display("FAIL halt_state: got pc %h acc %h want 3 0a", pc, acc); else passed++;
      total++; if (retired !== (RC ? 32'd3 : 32'd0)) $display("FAIL halt_retired: got %0d want %0d", retired, RC ? 3 : 0); else passed++;
      n = act_q.size();
      repeat (20) @(negedge clk);
      total++; if (act_q.size() !== n || mif.mem_req !== 1'b0 || halted !== 1'b1) $display("FAIL halt_quiet: got %0d new acc req %b halted %b want 0 0 1", act_q.size() - n, mif.mem_req, halted); else passed++;
      pulse_resume();
      total++; if (halted !== 1'b0) $display("FAIL resume_halted: got %b want 0", halted); else passed++;
      @(negedge clk);
      total++; if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {1'b1, 1'b0, 5'd3}) $display("FAIL resume_fetch: got req %b we %b addr %h want 1 0 03", mif.mem_req, mif.mem_we, mif.mem_addr); else passed++;
      run_to_halt(60, cyc, ok);
      total++; if (pc !== 5'd4 || retired !== (RC ? 32'd4 : 32'd0)) $display("FAIL resume_halt2: got pc %h retired %0d want 4 %0d", pc, retired, RC ? 4 : 0); else passed++;
   endtask

   task automatic test_reset_mid_write();
      int cyc;
      begin_reset();
      hold_we = 1'b1;
      mem[0] = 8'hB4; mem[1] = 8'hC9; mem[20] = 8'h55;
      end_reset();
      cyc = 0;
      while (!(mif.mem_req === 1'b1 && mif.mem_we === 1'b1) && cyc < 40) begin @(negedge clk); cyc++; end
      total++; if (cyc >= 40) $display("FAIL midwr_timeout: got no write req want write req"); else passed++;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0) $display("FAIL midwr_req_drop: got req %b we %b want 0 0", mif.mem_req, mif.mem_we); else passed++;
      total++; if (acc !== 8'h00 || pc !== 5'd0) $display("FAIL midwr_regs: got acc %h pc %h want 00 0", acc, pc); else passed++;
      hold_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (mif.mem_req !== 1'b1 && cyc < 10);
      total++; if (mif.mem_addr !== 5'd0 || acc !== 8'h00) $display("FAIL midwr_restart: got addr %h acc %h want 0 00", mif.mem_addr, acc); else passed++;
      total++; if (nwrites !== 0 || mem[9] !== 8'h00) $display("FAIL midwr_abandoned: got %0d writes mem9 %h want 0 00", nwrites, mem[9]); else passed++;
   endtask

   task automatic test_wide();
      int cyc;
      for (int i = 0; i < 256; i++) memw[i] = 16'h0000;
      memw[0] = 16'hA010; memw[1] = 16'h4011; memw[2] = 16'h0000;
      memw[16] = 16'hFFFF; memw[17] = 16'h0002;
      @(negedge clk);
      rst_w = 1'b0;
      cyc = 0;
      while (halted_w !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
      total++; if (halted_w !== 1'b1) $display("FAIL wide_halt_timeout: got running want halted"); else passed++;
      total++; if (acc_w !== 16'h0001 || zero_w !== 1'b0) $display("FAIL wide_add: got %h zero %b want 0001 0", acc_w, zero_w); else passed++;
      total++; if (pc_w !== 8'd3 || retired_w !== (RC ? 32'd3 : 32'd0)) $display("FAIL wide_pc: got pc %h retired %0d want 03 %0d", pc_w, retired_w, RC ? 3 : 0); else passed++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_skz_jmp();
      test_wait_states();
      test_halt_resume();
      test_reset_mid_write();
      test_wide();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/acc_core_mc.md
Name: acc_core_mc

Overview:
- Parametrised multi-cycle accumulator CPU core; the successor to the fixed 8-bit/5-bit datapath.
- Instruction word is a 3-bit opcode in the MSBs plus an operand address in the LSBs.
- A single controller FSM sequences fetch, decode, operand read and store.
- Talks to an external single-port memory over a req/ack handshake that tolerates wait states; this replaces the old fixed-timing internal memory coupling.

Parameters:
- DATA_W, 8, accumulator / memory word width; must be >= ADDR_W+3.
- ADDR_W, 5, PC and operand address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data (ACC).
- mem_rdata  in  DATA_W  read data; sampled on the cycle mem_ack=1.
- mem_ack  in  1  access complete.
- resume  in  1  leave HALT state.
- pc  out  ADDR_W  current program counter.
- acc  out  DATA_W  accumulator.
- zero  out  1  combinational, acc==0.
- halted  out  1  1 while in HALT.
- retired  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (async, active-high): state=FETCH, pc=RESET_PC, acc=0, ir=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, retired=0.
- Field decode: opcode=ir[DATA_W-1:DATA_W-3]; oper=ir[ADDR_W-1:0]; bits between the two fields are ignored.
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- Handshake (all outputs registered):
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the cycle mem_ack=1.
  - mem_req deasserts the cycle after ack, except when the FSM immediately issues the next access.
  - Ack may arrive in the first req cycle (zero wait).
  - mem_ack while mem_req=0 is ignored.
- FETCH: req read at pc. On ack: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W, 2^ADDR_W-1 wraps to 0) -> DECODE.
- DECODE (1 cycle, no memory access):
  - HLT -> HALT.
  - SKZ: if acc==0, pc<=pc+1 (wraps) -> FETCH.
  - JMP: pc<=oper -> FETCH.
  - ADD/AND/XOR/LDA -> READ.
  - STO -> WRITE.
- READ: req read at oper. On ack, acc is updated then -> FETCH:
  - ADD: acc+rdata mod 2^DATA_W, carry discarded.
  - AND: acc&rdata.
  - XOR: acc^rdata.
  - LDA: rdata.
- WRITE: req write at oper, wdata=acc. On ack -> FETCH.
- HALT: halted=1, no requests.
  - resume=1 -> FETCH with pc unchanged, i.e. the instruction after HLT.
  - resume outside HALT is ignored.
- Latency with zero-wait memory (fetch completes one cycle after mem_req assertion):
  - SKZ/JMP: 3 cycles.
  - ADD/AND/XOR/LDA/STO: 5 cycles.
  - HLT: 3 cycles.
  - Each memory wait cycle adds 1.
- Instruction retires on the transition DECODE->FETCH (SKZ/JMP), READ/WRITE->FETCH, or DECODE->HALT.
- Reset mid-access: all outputs return to reset values asynchronously. A pending STO write is abandoned; the memory must tolerate req dropping without ack.
- Self-modifying code is allowed; STO to the address being fetched next takes effect on that fetch.

Optional Feature:
- Macro: ACC_CORE_RETIRE_CNT_EN.
- Defined:
  - retired is a 32-bit counter, +1 per retired instruction, wrapping at 2^32.
  - Cleared only by rst; HALT holds its value.
- Undefined: retired is tied to 0 and no counter flops are inferred.

Test Plan:
- Reset/fetch: rst high then low, zero-wait mem, mem[0]=LDA 5 (0xA5), mem[5]=0x3C -> first req at addr 0; acc=0x3C and pc=1 five cycles after the first req.
- ALU wrap: acc=0xF0, ADD with mem=0x20 -> acc=0x10, zero=0. Then XOR with 0x10 -> acc=0x00, zero=1.
- SKZ/JMP: acc=0, SKZ at pc=3 -> next fetch at 5. acc=0x01 -> next fetch at 4. JMP 31 at pc=31 -> pc stays 31 forever, no writes. pc=31 fetch of a non-jump -> pc wraps to 0.
- Wait states: ack delayed 3 cycles on every access -> req/we/addr/wdata stable throughout; STO of acc=0x77 to addr 9 writes exactly once; results identical to zero-wait run.
- Halt/resume: HLT at pc=2 -> halted=1, no req for 20 cycles. resume pulse -> fetch at addr 3, halted=0. retired increments by 1 for the HLT when macro defined, stays 0 when undefined.
- Async reset mid-WRITE with ack withheld -> mem_req falls within the same cycle; after release, fetch restarts at RESET_PC with acc=0. Also run with DATA_W=16, ADDR_W=8: ADD 0xFFFF+0x0002 -> 0x0001.
